// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared types and constants for the seven-segment scan driver
package seg7_scan_driver_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Pick nibble i out of a packed 4-digit word (digit 0 in bits 3:0)
    function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] i);
        return word[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// rtl/seg7_scan_driver_hex_to_seg7.sv - combinational hex to active-low seven-segment decoder
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment
    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered 4-digit multiplexed seven-segment scan driver
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d_disp0,
    input  logic [3:0] d_disp1,
    input  logic [3:0] d_disp2,
    input  logic [3:0] d_disp3,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_start
);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    slot_state_e      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      pend_q, pend_d;
    logic [15:0]      frame_q, frame_d;

    logic [15:0] load_word;
    logic [6:0]  dec_seg;
    logic        z3, z2, z1;
    logic        digit_blanked;

    assign load_word = {d_disp3, d_disp2, d_disp1, d_disp0};

    hex_to_seg7 u_dec (
        .hex (nibble_of(frame_q, idx_q)),
        .seg (dec_seg)
    );

    // Slot sequencing and buffer swap; the frame register only changes when digit 0 is about to start
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        pend_d  = load ? load_word : pend_q;
        frame_d = frame_q;
        if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                cnt_d   = '0;
                state_d = ST_DRIVE;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    // A same-cycle load bypasses pend so it lands in this frame
                    frame_d = load ? load_word : pend_q;
                end
            end
        end else begin
            if (cnt_q == DRIVE_LAST) begin
                cnt_d   = '0;
                state_d = ST_BLANK;
            end
        end
    end

    // State registers with synchronous active-low reset; idx starts at 3 so the first slot is digit 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_BLANK;
            idx_q   <= 2'd3;
            cnt_q   <= '0;
            pend_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
        end
    end

    // Leading-zero blanking: a digit is dark when it and every digit to its left are zero
    always_comb begin
        z3 = blank_lz && (frame_q[15:12] == 4'h0);
        z2 = z3 && (frame_q[11:8] == 4'h0);
        z1 = z2 && (frame_q[7:4] == 4'h0);
        case (idx_q)
            2'd3:    digit_blanked = z3;
            2'd2:    digit_blanked = z2;
            2'd1:    digit_blanked = z1;
            default: digit_blanked = 1'b0;
        endcase
    end

    // Output decode straight from registers; blanked slots keep timing but stay dark
    always_comb begin
        an          = AN_OFF;
        seg         = SEG_OFF;
        frame_start = (state_q == ST_DRIVE) && (idx_q == 2'd0) && (cnt_q == '0);
        if (state_q == ST_DRIVE && !digit_blanked) begin
            an  = ~(4'b0001 << idx_q);
            seg = dec_seg;
        end
    end

endmodule
